// File: rtl/alu_seq_ctrl.sv
// Operand/opcode sequencer for the Basys3 ALU: loads op1, op2, opcode from switches
// on button presses, drives a combinational ALU and captures its result and carry.
module alu_seq_ctrl #(
   parameter int NB_DATA   = 8,
   parameter int NB_OPCODE = 6,
   parameter int NB_SYNC   = 2
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NB_DATA-1:0]   i_sw,
   input  logic                 i_btn_op1,
   input  logic                 i_btn_op2,
   input  logic                 i_btn_opcode,
   input  logic                 i_btn_clear,
   output logic [NB_DATA-1:0]   o_op_1,
   output logic [NB_DATA-1:0]   o_op_2,
   output logic [NB_OPCODE-1:0] o_opcode,
   input  logic [NB_DATA-1:0]   i_alu_result,
   input  logic                 i_alu_carry,
   output logic [NB_DATA-1:0]   o_result,
   output logic                 o_carry,
   output logic                 o_valid,
   output logic [2:0]           o_state,
   output logic                 o_seq_err
);

   typedef enum logic [2:0] {
      S_WAIT_A  = 3'd0,
      S_WAIT_B  = 3'd1,
      S_WAIT_OP = 3'd2,
      S_EXEC    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam int NB_BTN = 4;  // index order is also the priority order

   // Async assert, sync release of the internal reset.
   logic [1:0] rst_meta;
   logic       rst;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) rst_meta <= 2'b11;
      else         rst_meta <= {rst_meta[0], 1'b0};
   end
   assign rst = rst_meta[1];

   logic [NB_BTN-1:0]              btn_raw;
   logic [NB_BTN-1:0][NB_SYNC-1:0] sync_q;
   logic [NB_BTN-1:0]              edge_q;
   logic [NB_BTN-1:0]              armed;
   logic [NB_SYNC-1:0]             fill;
   logic [NB_BTN-1:0]              pulse;
   logic [NB_BTN-1:0]              sel;

   assign btn_raw = {i_btn_opcode, i_btn_op2, i_btn_op1, i_btn_clear};

   // A button is armed only after its synchronized level has been seen low once
   // with real samples, so a button held through reset release is ignored.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         edge_q <= '0;
         armed  <= '0;
         fill   <= '0;
      end else begin
         fill <= {fill[NB_SYNC-2:0], 1'b1};
         for (int i = 0; i < NB_BTN; i++) begin
            sync_q[i] <= {sync_q[i][NB_SYNC-2:0], btn_raw[i]};
            edge_q[i] <= sync_q[i][NB_SYNC-1];
            if (fill[NB_SYNC-1] && !sync_q[i][NB_SYNC-1]) armed[i] <= 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NB_BTN; i++)
         pulse[i] = sync_q[i][NB_SYNC-1] & ~edge_q[i] & armed[i];
   end

   // Keep only the lowest-index (highest-priority) pulse.
   assign sel = pulse & (~pulse + 4'd1);

   state_t state, state_next;
   logic   ld_op1, ld_op2, ld_opc, capture, clr, inval, err;

   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) state <= S_WAIT_A;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      ld_op1     = 1'b0;
      ld_op2     = 1'b0;
      ld_opc     = 1'b0;
      capture    = 1'b0;
      clr        = 1'b0;
      inval      = 1'b0;
      err        = 1'b0;
      if (state != S_EXEC && sel[0]) begin
         clr        = 1'b1;
         state_next = S_WAIT_A;
      end else begin
         case (state)
            S_WAIT_A: begin
               if (sel[1]) begin
                  ld_op1     = 1'b1;
                  state_next = S_WAIT_B;
               end else if (|sel) err = 1'b1;
            end
            S_WAIT_B: begin
               if (sel[1]) ld_op1 = 1'b1;
               else if (sel[2]) begin
                  ld_op2     = 1'b1;
                  state_next = S_WAIT_OP;
               end else if (|sel) err = 1'b1;
            end
            S_WAIT_OP: begin
               if (sel[3]) begin
                  ld_opc     = 1'b1;
                  state_next = S_EXEC;
               end else if (|sel) err = 1'b1;
            end
            S_EXEC: begin
               capture    = 1'b1;
               state_next = S_DONE;
            end
            S_DONE: begin
               if (sel[1]) begin
                  ld_op1     = 1'b1;
                  inval      = 1'b1;
                  state_next = S_WAIT_B;
               end else if (sel[3]) begin
                  ld_opc     = 1'b1;
                  inval      = 1'b1;
                  state_next = S_EXEC;
               end else if (|sel) err = 1'b1;
            end
            default: state_next = S_WAIT_A;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         o_op_1    <= '0;
         o_op_2    <= '0;
         o_opcode  <= '0;
         o_result  <= '0;
         o_carry   <= 1'b0;
         o_valid   <= 1'b0;
         o_seq_err <= 1'b0;
      end else begin
         o_seq_err <= err;
         if (clr) begin
            o_op_1   <= '0;
            o_op_2   <= '0;
            o_opcode <= '0;
            o_result <= '0;
            o_carry  <= 1'b0;
            o_valid  <= 1'b0;
         end else begin
            if (ld_op1) o_op_1   <= i_sw;
            if (ld_op2) o_op_2   <= i_sw;
            if (ld_opc) o_opcode <= i_sw[NB_OPCODE-1:0];
            if (inval)  o_valid  <= 1'b0;
            if (capture) begin
               o_result <= i_alu_result;
               o_carry  <= i_alu_carry;
               o_valid  <= 1'b1;
            end
         end
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU attached.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       i_reset;
   logic [7:0] i_sw;
   logic       b_op1, b_op2, b_opc, b_clr;
   logic [7:0] op_1, op_2, result, alu_res;
   logic [5:0] opcode;
   logic       alu_c, carry, valid, seq_err;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.NB_DATA(8), .NB_OPCODE(6), .NB_SYNC(2)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_sw(i_sw),
      .i_btn_op1(b_op1), .i_btn_op2(b_op2), .i_btn_opcode(b_opc), .i_btn_clear(b_clr),
      .o_op_1(op_1), .o_op_2(op_2), .o_opcode(opcode),
      .i_alu_result(alu_res), .i_alu_carry(alu_c),
      .o_result(result), .o_carry(carry), .o_valid(valid),
      .o_state(state), .o_seq_err(seq_err)
   );

   always_comb begin
      alu_res = 8'h00;
      alu_c   = 1'b0;
      case (opcode)
         6'h20: {alu_c, alu_res} = {1'b0, op_1} + {1'b0, op_2};
         6'h22: alu_res = op_1 - op_2;
         6'h24: alu_res = op_1 & op_2;
         6'h25: alu_res = op_1 | op_2;
         6'h26: alu_res = op_1 ^ op_2;
         6'h27: alu_res = ~(op_1 | op_2);
         6'h03: alu_res = $unsigned($signed(op_1) >>> op_2);
         6'h02: alu_res = op_1 >> op_2;
         default: alu_res = 8'h00;
      endcase
   end

   always @(negedge clk) if (seq_err) err_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: b_clr = v;
         1: b_op1 = v;
         2: b_op2 = v;
         default: b_opc = v;
      endcase
   endtask

   task automatic press(input int b, input logic [7:0] sw);
      @(negedge clk);
      i_sw = sw;
      set_btn(b, 1'b1);
      repeat (4) @(negedge clk);
      set_btn(b, 1'b0);
      repeat (4) @(negedge clk);
   endtask

   // Press opcode, catch the single S_EXEC cycle, then check the capture.
   task automatic exec_op(input string tag, input logic [7:0] sw,
                          input logic [7:0] exp_res, input logic exp_c);
      bit found = 0;
      @(negedge clk);
      i_sw  = sw;
      b_opc = 1'b1;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (state == 3'd3) found = 1;
      end
      chk({tag, "_exec_seen"}, 32'(found), 32'd1);
      chk({tag, "_valid_in_exec"}, 32'(valid), 32'd0);
      @(negedge clk);
      chk({tag, "_state_done"}, 32'(state), 32'd4);
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_result"}, 32'(result), 32'(exp_res));
      chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
      b_opc = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int e0;
      i_reset = 1'b1;
      i_sw = 8'h00;
      b_op1 = 0; b_op2 = 0; b_opc = 0; b_clr = 0;
      repeat (3) @(negedge clk);
      chk("rst_op1", 32'(op_1), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      i_reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_result", 32'({carry, result, opcode, op_2}), 32'h0);
      chk("rst_err", 32'(seq_err), 32'h0);

      // op2 out of order from S_WAIT_A
      e0 = err_cnt;
      press(2, 8'h55);
      chk("ooo_err_cnt", 32'(err_cnt - e0), 32'd1);
      chk("ooo_op2", 32'(op_2), 32'h0);
      chk("ooo_state", 32'(state), 32'd0);

      // long hold on op1: exactly one load
      @(negedge clk);
      i_sw = 8'h11; b_op1 = 1'b1;
      repeat (6) @(negedge clk);
      i_sw = 8'h22;
      repeat (44) @(negedge clk);
      b_op1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("hold_state", 32'(state), 32'd1);
      chk("hold_op1", 32'(op_1), 32'h11);

      press(0, 8'h00);
      chk("clr_state", 32'(state), 32'd0);
      chk("clr_op1", 32'(op_1), 32'h0);

      // op1 and op2 coincide in S_WAIT_A
      e0 = err_cnt;
      @(negedge clk);
      i_sw = 8'h3C; b_op1 = 1'b1; b_op2 = 1'b1;
      repeat (4) @(negedge clk);
      b_op1 = 1'b0; b_op2 = 1'b0;
      repeat (4) @(negedge clk);
      chk("both_state", 32'(state), 32'd1);
      chk("both_op1", 32'(op_1), 32'h3C);
      chk("both_op2", 32'(op_2), 32'h0);
      chk("both_err", 32'(err_cnt - e0), 32'd0);

      // 5 + 3 with exact button latency on op1
      press(0, 8'h00);
      @(negedge clk);
      i_sw = 8'h05; b_op1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("lat_before", 32'(state), 32'd0);
      @(negedge clk);
      chk("lat_state", 32'(state), 32'd1);
      chk("lat_op1", 32'(op_1), 32'h05);
      b_op1 = 1'b0;
      repeat (4) @(negedge clk);
      press(2, 8'h03);
      chk("add1_state2", 32'(state), 32'd2);
      exec_op("add1", 8'h20, 8'h08, 1'b0);

      // FF + 01 carries, then AND re-exec from S_DONE
      press(1, 8'hFF);
      chk("add2_inval", 32'(valid), 32'd0);
      chk("add2_state1", 32'(state), 32'd1);
      press(2, 8'h01);
      exec_op("add2", 8'h20, 8'h00, 1'b1);
      exec_op("and", 8'h24, 8'h01, 1'b0);

      press(1, 8'h80);
      press(2, 8'h02);
      exec_op("sra", 8'h03, 8'hE0, 1'b0);
      exec_op("srl", 8'h02, 8'h20, 1'b0);

      // op2 in S_DONE is out of order and changes nothing
      e0 = err_cnt;
      press(2, 8'h77);
      chk("done_err", 32'(err_cnt - e0), 32'd1);
      chk("done_keep", 32'({state, valid, op_2, result}), {15'h0, 3'd4, 1'b1, 8'h02, 8'h20});

      // clear in S_WAIT_OP
      press(1, 8'h12);
      press(2, 8'h34);
      chk("wop_state", 32'(state), 32'd2);
      press(0, 8'h00);
      chk("wop_clr", 32'({state, valid, carry, op_1, op_2, result}), 32'h0);

      // reset during S_EXEC, with op1 held through release
      press(1, 8'h40);
      press(2, 8'h01);
      begin
         bit found = 0;
         @(negedge clk);
         i_sw = 8'h20; b_opc = 1'b1;
         for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (state == 3'd3) found = 1;
         end
         chk("rexec_seen", 32'(found), 32'd1);
      end
      i_reset = 1'b1;
      #1;
      chk("rexec_async", 32'({state, valid, op_1, op_2}), 32'h0);
      b_opc = 1'b0;
      i_sw = 8'h77; b_op1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rexec_valid", 32'({valid, result}), 32'h0);
      i_reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("held_state", 32'(state), 32'd0);
      chk("held_op1", 32'(op_1), 32'h0);
      b_op1 = 1'b0;
      repeat (4) @(negedge clk);
      press(1, 8'h77);
      chk("repress_state", 32'(state), 32'd1);
      chk("repress_op1", 32'(op_1), 32'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Operand/opcode sequencer for the Basys3 ALU top level. It loads the first operand, the second operand and the opcode from the board switches, one per button press and in a fixed order, and drives them into the combinational ALU. It then captures the ALU result and carry into output registers for the LEDs. All state is held here, so the ALU stays purely combinational.

## Interface
- NB_DATA, 8, operand/result width
- NB_OPCODE, 6, opcode width (taken from i_sw[NB_OPCODE-1:0])
- NB_SYNC, 2, button synchronizer depth (>=2)

- i_clk  in  1  single system clock
- i_reset  in  1  asynchronous, active-high reset
- i_sw  in  NB_DATA  switch value to load
- i_btn_op1 / i_btn_op2 / i_btn_opcode / i_btn_clear  in  1 each  debounced, asynchronous button levels
- o_op_1, o_op_2  out  NB_DATA  registered operands to ALU
- o_opcode  out  NB_OPCODE  registered opcode to ALU
- i_alu_result  in  NB_DATA  ALU result (combinational from o_op_*/o_opcode)
- i_alu_carry  in  1  ALU carry
- o_result  out  NB_DATA  captured result
- o_carry  out  1  captured carry
- o_valid  out  1  o_result/o_carry hold a result for the current operands/opcode
- o_state  out  3  current FSM state encoding
- o_seq_err  out  1  one-cycle pulse on an out-of-order press

## Operation
- Each button passes through an NB_SYNC-flop synchronizer and a rising-edge detector. A held button produces exactly one pulse.
- Edge priority when pulses coincide in one cycle: clear > op1 > op2 > opcode. Only the highest pulse is acted on. Lower ones are discarded silently (no o_seq_err).
- States: S_WAIT_A=0, S_WAIT_B=1, S_WAIT_OP=2, S_EXEC=3, S_DONE=4.
- S_WAIT_A: op1 -> o_op_1<=i_sw, go S_WAIT_B.
- S_WAIT_B: op2 -> o_op_2<=i_sw, go S_WAIT_OP. op1 -> reload o_op_1, stay.
- S_WAIT_OP: opcode -> o_opcode<=i_sw[NB_OPCODE-1:0], go S_EXEC.
- S_EXEC: unconditional, one cycle. o_result<=i_alu_result, o_carry<=i_alu_carry, o_valid<=1, go S_DONE. Button pulses in this cycle are ignored.
- S_DONE:
  - op1 -> o_op_1<=i_sw, o_valid<=0, go S_WAIT_B.
  - opcode -> o_opcode<=new value, o_valid<=0, go S_EXEC (re-execute on the same operands).
- Any other press not listed for a state pulses o_seq_err for one cycle. Registers and state are unchanged.
- clear (any state): all data registers <=0, o_valid<=0, go S_WAIT_A.
- Outputs are not modified outside the events listed. o_result/o_carry keep their last values while o_valid=0.

## Timing
- Reset (async assert, sync release): o_op_1=o_op_2=0, o_opcode=0, o_result=0, o_carry=0, o_valid=0, o_seq_err=0, state S_WAIT_A, synchronizer and edge flops=0.
- Button latency: the first rising edge sampling the button high is edge k. The register load/state change occurs at edge k+NB_SYNC.
- Opcode load at edge n -> ALU inputs settle during cycle n..n+1 -> capture and o_valid=1 at edge n+1.
- o_seq_err is high for exactly the cycle following the offending pulse's detection edge.
- Reset asserted mid-sequence (including S_EXEC) aborts immediately. A button still held at reset release does not generate a pulse until released and pressed again.

## Test plan
- Bench instantiates alu_seq_ctrl with the ALU. Sequence sw=0x05 op1, sw=0x03 op2, sw=0x20 (ADD) opcode -> o_result=0x08, o_carry=0, o_valid=1 exactly 1 cycle after the opcode load; o_state sequence 0,1,2,3,4.
- sw=0xFF, 0x01, ADD -> o_result=0x00, o_carry=1. Then opcode press sw=0x24 (AND) in S_DONE -> o_valid drops for one cycle, then o_result=0x01.
- Operands 0x80, 0x02, opcode 0x03 (SRA) -> o_result=0xE0. Re-run with opcode 0x02 (SRL) -> o_result=0x20.
- From reset, press op2 with sw=0x55 -> o_seq_err pulses one cycle, o_op_2 stays 0x00, state stays 0. Hold op1 for 50 cycles -> single load, state 1 only.
- op1 and op2 asserted in the same cycle in S_WAIT_A -> only the op1 load, no o_seq_err. clear pressed in S_WAIT_OP -> all outputs 0, state 0.
- Assert i_reset during S_EXEC -> outputs 0 asynchronously, o_valid never set. After release, button held -> no load until release and re-press.
